// File: rtl/regfile_uart_loader_pkg.sv
// Shared types and constants for the UART-driven register file loader.
`default_nettype none

package regfile_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         CNT_W     = 16;

  function automatic int bpw(input int dw);
    return (dw + 7) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_uart_loader_if.sv
// Byte-stream handshake and register-file write port of the loader.
`default_nettype none

interface regfile_uart_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            put_byte;
  logic                  EN_put;
  logic                  RDY_put;
  logic [ADDR_WIDTH-1:0] ADDR_IN;
  logic [DATA_WIDTH-1:0] D_IN;
  logic                  WE;

  // master = loader side, slave = UART / register file side
  modport master (input put_byte, EN_put, output RDY_put, ADDR_IN, D_IN, WE);
  modport slave  (output put_byte, EN_put, input RDY_put, ADDR_IN, D_IN, WE);
endinterface

`default_nettype wire

// File: rtl/regfile_uart_loader_assembler.sv
// loader_word_assembler: merges little-endian bytes into a word, flags the last byte.
`default_nettype none

module loader_word_assembler
  import regfile_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            byte_i,
  input  logic                  strobe_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_done_o
);

  localparam int BPW = bpw(DATA_WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int AW  = BPW * 8;

  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] w_lane;
  logic                  w_last;

  // Lanes at or above DATA_WIDTH fall off in the truncating cast.
  assign w_lane      = DATA_WIDTH'(AW'(byte_i) << (8 * idx_q));
  assign w_last      = (idx_q == IW'(BPW - 1));
  assign word_o      = acc_q | w_lane;
  assign word_done_o = strobe_i & ~clear_i & w_last;

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (clear_i) begin
      acc_d = '0;
      idx_d = '0;
    end else if (strobe_i) begin
      if (w_last) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = word_o;
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_uart_loader.sv
// regfile_uart_loader: header-framed byte stream to register-file writes with status.
// Define REGFILE_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte.
`default_nettype none

module regfile_uart_loader
  import regfile_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LO         = 0,
  parameter int HI         = 255
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  regfile_uart_loader_if.master bus,
  input  logic                  clr,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      load_count
);

  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(HI - LO + 1);
`ifdef REGFILE_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, widx_q, widx_d, lc_q, lc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, w_addr;
  logic [DATA_WIDTH-1:0] din_q, din_d, w_word;
  logic                  we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic                  err_q, err_d, rdy_q, rdy_d;
  logic                  w_take, w_word_done;
  logic [CNT_W:0]        w_cnt_full;
`ifdef REGFILE_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign w_take     = bus.EN_put & rdy_q & ~clr;
  assign w_addr     = ADDR_WIDTH'(LO + int'(widx_q));
  assign w_cnt_full = {1'b0, bus.put_byte, cnt_q[7:0]};

  loader_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .byte_i      (bus.put_byte),
    .strobe_i    (w_take && (state_q == DATA)),
    .clear_i     (clr || (state_q != DATA)),
    .word_o      (w_word),
    .word_done_o (w_word_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    lc_d    = lc_q;
`ifdef REGFILE_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (clr) begin
      state_d = IDLE;
      lc_d    = '0;
    end else if (w_take) begin
      case (state_q)
        IDLE:   if (bus.put_byte == SYNC_BYTE) state_d = CNT_LO;
        CNT_LO: begin
          cnt_d[7:0] = bus.put_byte;
          state_d    = CNT_HI;
        end
        CNT_HI: begin
          cnt_d[15:8] = bus.put_byte;
          widx_d      = '0;
          lc_d        = '0;
`ifdef REGFILE_LOADER_CHECKSUM_EN
          csum_d      = '0;
`endif
          if (w_cnt_full > CAP)       state_d = ERR;
          else if (w_cnt_full == '0)  state_d = END_ST;
          else                        state_d = DATA;
        end
        DATA: begin
`ifdef REGFILE_LOADER_CHECKSUM_EN
          csum_d = csum_q + bus.put_byte;
`endif
          if (w_word_done) begin
            we_d   = 1'b1;
            addr_d = w_addr;
            din_d  = w_word;
            lc_d   = lc_q + CNT_W'(1);
            widx_d = widx_q + CNT_W'(1);
            if (widx_q == cnt_q - CNT_W'(1)) state_d = END_ST;
          end
        end
`ifdef REGFILE_LOADER_CHECKSUM_EN
        CSUM:   state_d = (bus.put_byte == csum_q) ? DONE : ERR;
`endif
        default: ;
      endcase
    end
    // Status flags are pure functions of the next state, so they stay sticky with it.
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
    busy_d = !(state_d inside {IDLE, DONE, ERR});
    rdy_d  = !(state_d inside {DONE, ERR});
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      addr_q  <= ADDR_WIDTH'(LO);
      din_q   <= '0;
      we_q    <= 1'b0;
      lc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
`ifdef REGFILE_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      lc_q    <= lc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
`ifdef REGFILE_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bus.RDY_put = rdy_q;
  assign bus.ADDR_IN = addr_q;
  assign bus.D_IN    = din_q;
  assign bus.WE      = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;
  assign load_count  = lc_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_uart_loader.sv
// Directed bench for regfile_uart_loader: vector table plus corner-case sequences.
`default_nettype none

module tb_regfile_uart_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        clr = 1'b0, clr_s = 1'b0;
  logic        busy, done, error, busy_s, done_s, error_s;
  logic [15:0] load_count, load_count_s;
  int          n_tests = 0;
  int          n_fail = 0;
  int          we_cnt_s = 0;

  always #5 CLK = ~CLK;

  regfile_uart_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  regfile_uart_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_s ();

  regfile_uart_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LO(0), .HI(255)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus), .clr(clr),
    .busy(busy), .done(done), .error(error), .load_count(load_count)
  );

  regfile_uart_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LO(0), .HI(3)) dut_s (
    .CLK(CLK), .RST_N(RST_N), .bus(bus_s), .clr(clr_s),
    .busy(busy_s), .done(done_s), .error(error_s), .load_count(load_count_s)
  );

  always @(posedge CLK) if (bus_s.WE) we_cnt_s++;

  typedef struct {
    logic [7:0]  b;
    logic        en;
    logic        c;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        done;
    logic        err;
    logic        busy;
    logic        rdy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic [7:0] b, input logic en, input logic c, input logic we,
                     input logic [7:0] addr, input logic [31:0] data, input logic dn,
                     input logic er, input logic bs, input logic rd, input logic [15:0] cnt);
    vec_t v;
    v.b = b; v.en = en; v.c = c; v.we = we; v.addr = addr; v.data = data;
    v.done = dn; v.err = er; v.busy = bs; v.rdy = rd; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] b, input logic en, input logic c);
    @(negedge CLK);
    bus.put_byte = b; bus.EN_put = en; clr = c;
    @(posedge CLK);
    #1;
    bus.EN_put = 1'b0; clr = 1'b0;
  endtask

  task automatic step_s(input logic [7:0] b, input logic en, input logic c);
    @(negedge CLK);
    bus_s.put_byte = b; bus_s.EN_put = en; clr_s = c;
    @(posedge CLK);
    #1;
    bus_s.EN_put = 1'b0; clr_s = 1'b0;
  endtask

  function automatic logic [63:0] pack_main();
    return {3'b0, bus.WE, bus.ADDR_IN, bus.D_IN, done, error, busy, bus.RDY_put, load_count};
  endfunction

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    bus.put_byte = 8'h00; bus.EN_put = 1'b0;
    bus_s.put_byte = 8'h00; bus_s.EN_put = 1'b0;

    // reset state while held in reset
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_values", pack_main(), {3'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0});
    chk("reset_values_s", {busy_s, done_s, error_s, bus_s.RDY_put}, 64'b0001);
    @(negedge CLK);
    RST_N = 1'b1;

    // basic two-word load, back-to-back with one idle cycle mid-word
    row(8'hA5, 1, 0, 0, 8'h00, 32'h0, 0, 0, 1, 1, 0);
    row(8'h02, 1, 0, 0, 8'h00, 32'h0, 0, 0, 1, 1, 0);
    row(8'h00, 1, 0, 0, 8'h00, 32'h0, 0, 0, 1, 1, 0);
    row(8'h78, 1, 0, 0, 8'h00, 32'h0, 0, 0, 1, 1, 0);
    row(8'h56, 1, 0, 0, 8'h00, 32'h0, 0, 0, 1, 1, 0);
    row(8'h99, 0, 0, 0, 8'h00, 32'h0, 0, 0, 1, 1, 0);
    row(8'h34, 1, 0, 0, 8'h00, 32'h0, 0, 0, 1, 1, 0);
    row(8'h12, 1, 0, 1, 8'h00, 32'h12345678, 0, 0, 1, 1, 1);
    row(8'hEF, 1, 0, 0, 8'h00, 32'h12345678, 0, 0, 1, 1, 1);
    row(8'hBE, 1, 0, 0, 8'h00, 32'h12345678, 0, 0, 1, 1, 1);
    row(8'hAD, 1, 0, 0, 8'h00, 32'h12345678, 0, 0, 1, 1, 1);
`ifdef REGFILE_LOADER_CHECKSUM_EN
    row(8'hDE, 1, 0, 1, 8'h01, DB, 0, 0, 1, 1, 2);
    row(8'h4C, 1, 0, 0, 8'h01, DB, 1, 0, 0, 0, 2);
`else
    row(8'hDE, 1, 0, 1, 8'h01, DB, 1, 0, 0, 0, 2);
`endif
    row(8'hA5, 1, 0, 0, 8'h01, DB, 1, 0, 0, 0, 2);
    row(8'h00, 0, 1, 0, 8'h01, DB, 0, 0, 0, 1, 0);
    // sync hunt then zero-length load
    row(8'h00, 1, 0, 0, 8'h01, DB, 0, 0, 0, 1, 0);
    row(8'hFF, 1, 0, 0, 8'h01, DB, 0, 0, 0, 1, 0);
    row(8'hA5, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h00, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
`ifdef REGFILE_LOADER_CHECKSUM_EN
    row(8'h00, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
`endif
    row(8'h00, 1, 0, 0, 8'h01, DB, 1, 0, 0, 0, 0);
    row(8'h00, 0, 1, 0, 8'h01, DB, 0, 0, 0, 1, 0);
    // abort mid-word (byte offered with clr is dropped), then clean 1-word load
    row(8'hA5, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h01, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h00, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h11, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h22, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h33, 1, 1, 0, 8'h01, DB, 0, 0, 0, 1, 0);
    row(8'hA5, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h01, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h00, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h44, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h55, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
    row(8'h66, 1, 0, 0, 8'h01, DB, 0, 0, 1, 1, 0);
`ifdef REGFILE_LOADER_CHECKSUM_EN
    row(8'h77, 1, 0, 1, 8'h00, 32'h77665544, 0, 0, 1, 1, 1);
    row(8'h76, 1, 0, 0, 8'h00, 32'h77665544, 1, 0, 0, 0, 1);
`else
    row(8'h77, 1, 0, 1, 8'h00, 32'h77665544, 1, 0, 0, 0, 1);
`endif
    row(8'h00, 0, 1, 0, 8'h00, 32'h77665544, 0, 0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].b, tbl[i].en, tbl[i].c);
      chk($sformatf("vec[%0d]", i), pack_main(),
          {3'b0, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].done, tbl[i].err,
           tbl[i].busy, tbl[i].rdy, tbl[i].cnt});
    end

    // overflow on HI=3 instance, then exactly-CAP header accepted
    step_s(8'hA5, 1, 0);
    step_s(8'h05, 1, 0);
    step_s(8'h00, 1, 0);
    chk("overflow_err", {busy_s, done_s, error_s, bus_s.RDY_put}, 64'b0010);
    step_s(8'hA5, 1, 0);
    chk("err_sticky", {busy_s, error_s, bus_s.RDY_put, load_count_s}, {45'b0, 1'b0, 1'b1, 1'b0, 16'h0});
    step_s(8'h00, 0, 1);
    chk("clr_from_err", {busy_s, done_s, error_s, bus_s.RDY_put}, 64'b0001);
    step_s(8'hA5, 1, 0);
    step_s(8'h04, 1, 0);
    step_s(8'h00, 1, 0);
    chk("cap_accepted", {busy_s, done_s, error_s, bus_s.RDY_put}, 64'b1001);
    step_s(8'h00, 0, 1);
    chk("no_we_small", 64'(we_cnt_s), 64'd0);

`ifdef REGFILE_LOADER_CHECKSUM_EN
    // checksum match then mismatch; the word is written either way
    step(8'hA5, 1, 0); step(8'h01, 1, 0); step(8'h00, 1, 0);
    step(8'h01, 1, 0); step(8'h02, 1, 0); step(8'h03, 1, 0); step(8'h04, 1, 0);
    chk("csum_we", {bus.WE, bus.ADDR_IN, bus.D_IN}, {23'b0, 1'b1, 8'h00, 32'h04030201});
    step(8'h0A, 1, 0);
    chk("csum_ok", {done, error, busy, bus.RDY_put}, 64'b1000);
    step(8'h00, 0, 1);
    step(8'hA5, 1, 0); step(8'h01, 1, 0); step(8'h00, 1, 0);
    step(8'h01, 1, 0); step(8'h02, 1, 0); step(8'h03, 1, 0); step(8'h04, 1, 0);
    chk("csum_bad_we", {bus.WE, bus.ADDR_IN, bus.D_IN}, {23'b0, 1'b1, 8'h00, 32'h04030201});
    step(8'h0B, 1, 0);
    chk("csum_bad", {done, error, busy, bus.RDY_put, load_count}, {44'b0, 4'b0100, 16'd1});
    step(8'h00, 0, 1);
`endif

    // asynchronous reset in the middle of DATA
    step(8'hA5, 1, 0); step(8'h02, 1, 0); step(8'h00, 1, 0);
    step(8'h11, 1, 0); step(8'h22, 1, 0); step(8'h33, 1, 0); step(8'h44, 1, 0);
    chk("pre_reset_busy", {busy, bus.WE, load_count}, {46'b0, 1'b1, 1'b1, 16'd1});
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_reset", pack_main(), {3'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0});
    @(negedge CLK);
    RST_N = 1'b1;
    step(8'h55, 1, 0);
    chk("idle_after_reset", {busy, done, bus.RDY_put}, 64'b001);
    step(8'hA5, 1, 0);
    chk("sync_after_reset", {busy, done, bus.RDY_put}, 64'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_uart_loader.md
Name: regfile_uart_loader

Overview:
- Upstream feeder for the multi-ported, hex-initialisable register file.
- Takes a byte stream from the UART receiver and assembles DATA_WIDTH-bit words, little-endian.
- Drives the register file's write port (ADDR_IN/D_IN/WE), so memory can be reloaded at run time without re-synthesising the init file.
- Reports busy/done/error status to the boot controller.

Parameters:
- ADDR_WIDTH, 8, register file address width
- DATA_WIDTH, 32, register file word width; BPW = ceil(DATA_WIDTH/8) bytes per word
- LO, 0, first address written
- HI, 255, last writable address; capacity CAP = HI-LO+1

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- put_byte  in  8  received byte
- EN_put  in  1  byte valid; consumed only when RDY_put=1
- RDY_put  out  1  loader can accept a byte
- clr  in  1  synchronous abort/restart pulse
- ADDR_IN  out  ADDR_WIDTH  write address to register file
- D_IN  out  DATA_WIDTH  write data to register file
- WE  out  1  write enable, single-cycle pulse per word
- busy  out  1  high in any state other than IDLE/DONE/ERR
- done  out  1  sticky, load completed
- error  out  1  sticky, load rejected
- load_count  out  16  words written in the current or last load

Behaviour:
- Reset (RST_N=0, asynchronous) puts the block in state IDLE with:
  - ADDR_IN=LO, D_IN=0, WE=0
  - done=0, error=0, busy=0, load_count=0, RDY_put=1
- All outputs are registered.
- Byte handshake:
  - A byte is accepted in a cycle where EN_put=1 and RDY_put=1.
  - RDY_put=1 in IDLE, CNT_LO, CNT_HI, DATA and CSUM; RDY_put=0 in DONE and ERR.
- States and transitions:
  - IDLE: accepted byte 0xA5 -> CNT_LO; any other byte is discarded and the block stays in IDLE.
  - CNT_LO: accepted byte -> cnt[7:0]; go to CNT_HI.
  - CNT_HI: accepted byte -> cnt[15:8]. Then:
    - cnt > CAP -> ERR.
    - cnt == 0 -> DONE (CSUM when the checksum feature is enabled).
    - otherwise -> DATA, with byte index=0, word index=0.
  - DATA: byte k of a word fills bits [8k+7:8k]; bits at or above DATA_WIDTH are dropped.
    - On the BPW-th byte, in the following cycle: WE=1, ADDR_IN=LO+word index, D_IN=assembled word, load_count increments.
    - Write latency is 1 cycle after the final byte is accepted.
    - The assembly register clears after each word.
    - After word cnt-1 is written -> DONE (CSUM when enabled).
  - DONE: done=1, holds until clr. ERR: error=1, holds until clr.
- Addressing: address never exceeds HI because cnt <= CAP is checked up front; there is no wrap-around.
- clr (any state, highest priority):
  - Next state IDLE; done and error cleared; load_count=0.
  - A byte presented in the same cycle is dropped.
  - A WE already scheduled for that cycle still completes; no further writes follow.
- Back-to-back bytes (EN_put every cycle) are sustained with no stalls. The WE for one word can coincide with acceptance of the next word's first byte.

Optional Feature:
- Macro: REGFILE_LOADER_CHECKSUM_EN.
- When defined:
  - State CSUM follows the last data byte (or follows CNT_HI when cnt=0) and expects one byte.
  - Expected value = 8-bit modular sum of all data bytes.
  - Match -> DONE; mismatch -> ERR.
  - Words already written stay written; error only flags the load.
- When undefined: CSUM does not exist; the last data word goes directly to DONE.

Decomposition:
- Package regfile_loader_pkg holds:
  - state enumeration {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR}
  - SYNC_BYTE=8'hA5
  - count width constant 16
  - BPW function
- One sub-module, loader_word_assembler:
  - Byte-lane shift/merge register with byte counter.
  - Inputs: byte, strobe, clear. Outputs: word, word_done.
  - The FSM, address generation and checksum stay in the top block.

Test Plan:
- Reset values: assert RST_N=0 mid-DATA -> all outputs at reset values immediately, without waiting for CLK; after release, state IDLE.
- Basic load (DATA_WIDTH=32, LO=0):
  - Stimulus: bytes A5 02 00 | 78 56 34 12 | EF BE AD DE.
  - Response: WE at addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF; done=1, load_count=2.
- Sync hunt and zero count:
  - Stimulus: bytes 00 FF A5 00 00.
  - Response: no WE; done=1 right after the 5th byte.
- Overflow (HI=3): header A5 05 00 -> error=1, RDY_put=0, no WE.
- Abort:
  - Stimulus: clr after 2 data bytes of the first word, then a full 1-word load.
  - Response: no partial write; next write goes to address LO with a clean assembled word.
- Checksum (macro defined):
  - Stimulus: A5 01 00 01 02 03 04 0A -> done=1.
  - Stimulus: same load with final byte 0B -> error=1, and WE for 0x04030201 still issued.
